isp_mode_ctrl: RTL and testbench
================================

Name: isp_mode_ctrl

Overview:
- Frame-synchronous configuration controller for the RAW-to-RGB post-processing chain.
- Synchronises and debounces the user switches that select demosaic algorithm, Gaussian filter, AWB and gamma.
- Commits a new configuration only at the vsync active edge, so a frame is never processed with mixed settings.
- Mutes output for a programmable number of frames after each change while the filter and AWB pipelines settle. Sits in the VGA_CLK domain between the board switches and the datapath muxes.

Parameters:
- DEB_CYCLES, 250000, cycles a switch pattern must be stable before it is accepted (10 ms at 25 MHz); must be >=1.
- FLUSH_FRAMES, 2, frames muted after a commit; 0 disables muting; must be <=15.
- VS_ACTIVE_LOW, 1, 1: the vsync active edge is 1->0; 0: the active edge is 0->1.

Ports:
- CLK in 1: VGA pixel clock, 25 MHz.
- RST_N in 1: synchronous, active-low reset.
- SW in 10: raw board switches. Only [9:4] are used; [3:0] are ignored.
- VGA_VS in 1: vsync, already in the CLK domain.
- oDM_SEL out 2: demosaic select. 0 = BIN, 1 = HQL, 2 = Hamilton; 3 is never driven.
- oGAUSS_EN out 1: Gaussian filter enable (from SW[7]).
- oAWB_EN out 1: AWB enable (from SW[6]).
- oGAMMA_EN out 1: gamma enable (from SW[5]).
- oGAMMA_SQ out 1: gamma curve select. 1 = square, 0 = sqrt (from SW[4]).
- oCFG_UPD out 1: one-cycle pulse on each commit.
- oAWB_CLR out 1: one-cycle pulse instructing AWB to restart its statistics.
- oMUTE out 1: downstream forces RGB to 0 while this is high.
- oBUSY out 1: high when the FSM is not in IDLE.

Behaviour:
- Reset (RST_N=0 at a CLK edge) forces:
  - synchronisers, candidate, stable and active config, debounce counter, frame counter and vsync history to 0;
  - all outputs to 0 (oDM_SEL=BIN, every enable 0, no pulses, oMUTE=0, oBUSY=0);
  - FSM to IDLE.
- Reset asserted mid-PENDING or mid-FLUSH aborts immediately: no commit, mute released.
- Synchronisation: SW[9:4] passes through a 2-FF synchroniser to sw_s.
- Config encoding: cfg_raw = {dm, sw_s[7], sw_s[6], sw_s[5], sw_s[4]} (6 bits).
  - dm = Hamilton if sw_s[9:8] = x1, HQL if 10, BIN if 00. SW[8] has priority over SW[9].
- Debounce:
  - if cfg_raw != cand: cand <= cfg_raw, cnt <= 0;
  - else if cnt < DEB_CYCLES-1: cnt++;
  - else: stable <= cand.
  - Latency: stable updates on the (DEB_CYCLES+3)th rising edge after the new SW value is first sampled.
  - Any bounce restarts the count; bursts shorter than DEB_CYCLES never reach stable.
- Vsync edge: vs_edge is a one-cycle detection of the active edge of VGA_VS, using a registered previous value.
  - The previous value resets to the inactive level, so no false edge is seen out of reset.
- FSM:
  - IDLE: if stable != active, go to PENDING.
  - PENDING:
    - if stable == active (user reverted before the frame edge), return to IDLE with no commit;
    - else on vs_edge:
      - active <= stable, oCFG_UPD = 1 for one cycle;
      - oAWB_CLR = 1 for the same cycle if the AWB enable goes 0->1 or dm changes;
      - if FLUSH_FRAMES > 0: fcnt <= FLUSH_FRAMES, oMUTE <= 1, go to FLUSH; else go to IDLE.
  - FLUSH: on each vs_edge, fcnt--. On the vs_edge where fcnt == 1: oMUTE <= 0, go to IDLE.
    - Stable changes during FLUSH are held. After returning to IDLE they are committed on a later vs_edge, never the one that ended FLUSH.
- Outputs oDM_SEL, oGAUSS_EN, oAWB_EN, oGAMMA_EN and oGAMMA_SQ are registered copies of active. They change on the same edge that oCFG_UPD asserts.
- stable changing in the same cycle as vs_edge in PENDING: the registered stable value at that edge is committed.
- oBUSY = (state != IDLE), registered.
- All counters saturate or wrap only as stated; the debounce counter is sized by $clog2(DEB_CYCLES).

Decomposition:
- Package isp_cfg_pkg holds:
  - demosaic codes DM_BIN=2'd0, DM_HQL=2'd1, DM_HAM=2'd2;
  - CFG_W=6 and the cfg field bit positions;
  - FSM state encoding S_IDLE, S_PEND, S_FLUSH.
- Sub-module sw_debounce (parameters W, DEB_CYCLES) contains the 2-FF synchroniser plus the debounce counter. It is reused for any future switch or key inputs.

Test Plan (DEB_CYCLES=4, FLUSH_FRAMES=2, VS_ACTIVE_LOW=1, vsync every 100 cycles):
- Reset: hold RST_N=0 for 3 cycles with SW=10'h3F0 -> all outputs 0. After release, no oCFG_UPD until the debounced value lands and a vs_edge occurs.
- Commit: SW=10'h100 at cycle 10 -> stable = Hamilton on the 7th edge after sampling; oBUSY=1. At the next VS 1->0: oDM_SEL=2, oCFG_UPD=1 and oAWB_CLR=1 (single cycle), oMUTE=1. oMUTE stays high for exactly 2 further vsync edges, then oBUSY=0.
- Bounce: toggle SW[7] every 3 cycles for 30 cycles, then return to its original value -> no oCFG_UPD and oGAUSS_EN unchanged.
- Revert in PENDING: set SW[6]=1, let it debounce, clear it before the vsync -> FSM returns to IDLE with no commit and no oAWB_CLR.
- Change during FLUSH: set SW[5]=1 one frame into FLUSH -> oGAMMA_EN=1 only at the first vs_edge after FLUSH ends, followed by a new 2-frame mute. oAWB_CLR=0 for this commit.
- Priority/gamma: SW=10'h330 -> oDM_SEL=2 (SW[8] wins), oGAMMA_EN=1, oGAMMA_SQ=1. Then SW=10'h220 -> oDM_SEL=1, oGAMMA_SQ=0, and oAWB_CLR pulses because dm changed.

Source files
------------

// File: rtl/isp_cfg_pkg.sv
// isp_cfg_pkg
//   Shared definitions for the ISP mode controller.
//   - demosaic select codes
//   - layout of the 6-bit configuration word {dm[1:0], gauss, awb, gammaEn, gammaSq}
//   - controller state encoding
//   - encodeCfg(): maps synchronised switches SW[9:4] onto a configuration word
package isp_cfg_pkg;

  localparam logic [1:0] DM_BIN = 2'd0;
  localparam logic [1:0] DM_HQL = 2'd1;
  localparam logic [1:0] DM_HAM = 2'd2;

  localparam int CFG_W     = 6;
  localparam int CFG_GSQ   = 0;
  localparam int CFG_GEN   = 1;
  localparam int CFG_AWB   = 2;
  localparam int CFG_GAUSS = 3;
  localparam int CFG_DM_LO = 4;
  localparam int CFG_DM_HI = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_FLUSH = 2'd2
  } ctrlState_t;

  // swS is SW[9:4]: swS[5]=SW9, swS[4]=SW8, swS[3:0]=SW[7:4].
  // SW8 selects Hamilton regardless of SW9.
  function automatic logic [CFG_W-1:0] encodeCfg(input logic [5:0] swS);
    logic [1:0] dm;
    if (swS[4])      dm = DM_HAM;
    else if (swS[5]) dm = DM_HQL;
    else             dm = DM_BIN;
    return {dm, swS[3:0]};
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce
//   Two-flop synchroniser followed by a stability filter. The synchronised
//   value is exported so the parent can re-encode it before filtering; the
//   filter then runs on candIn, which lets a parent debounce a derived code
//   (two raw patterns that encode the same value do not restart the count).
//   Ports:
//     clk       - sampling clock
//     rstN      - synchronous active-low reset
//     rawIn     - asynchronous switch/key inputs
//     syncOut   - rawIn after two flops
//     candIn    - value to be filtered (usually a function of syncOut)
//     stableOut - candIn once it has held for DEB_CYCLES+1 consecutive samples
module sw_debounce #(
  parameter int W          = 6,
  parameter int DEB_CYCLES = 250000
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic [W-1:0] rawIn,
  output logic [W-1:0] syncOut,
  input  logic [W-1:0] candIn,
  output logic [W-1:0] stableOut
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  cand;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync1     <= '0;
      sync2     <= '0;
      cand      <= '0;
      cnt       <= '0;
      stableOut <= '0;
    end else begin
      sync1 <= rawIn;
      sync2 <= sync1;
      if (candIn != cand) begin
        cand <= candIn;
        cnt  <= '0;
      end else if (cnt < CNT_LAST) begin
        cnt <= cnt + CW'(1);
      end else begin
        // Counter holds at CNT_LAST; stable keeps re-latching the same value.
        stableOut <= cand;
      end
    end
  end

  assign syncOut = sync2;

endmodule

// File: rtl/isp_mode_ctrl.sv
// isp_mode_ctrl
//   Frame-synchronous configuration controller for the RAW-to-RGB chain.
//   Board switches are synchronised and debounced; a changed configuration
//   is only committed on the active vsync edge so a frame never sees mixed
//   settings, and output is muted for FLUSH_FRAMES frames after each commit.
//   Ports:
//     CLK        - VGA pixel clock
//     RST_N      - synchronous active-low reset
//     SW[9:0]    - raw switches; [9:8] demosaic, [7] gauss, [6] awb,
//                  [5] gamma enable, [4] gamma square; [3:0] unused
//     VGA_VS     - vsync in the CLK domain
//     oDM_SEL    - demosaic select (0 BIN, 1 HQL, 2 Hamilton)
//     oGAUSS_EN, oAWB_EN, oGAMMA_EN, oGAMMA_SQ - committed enables
//     oCFG_UPD   - one-cycle pulse on each commit
//     oAWB_CLR   - one-cycle pulse: AWB restarts its statistics
//     oMUTE      - downstream forces RGB to 0 while high
//     oBUSY      - controller not idle
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | active config matches debounced switches
//   S_PEND  | new debounced config waiting for the next vsync edge
//   S_FLUSH | config committed, output muted until fcnt frames have passed
module isp_mode_ctrl
  import isp_cfg_pkg::*;
#(
  parameter int DEB_CYCLES    = 250000,
  parameter int FLUSH_FRAMES  = 2,
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [9:0] SW,
  input  logic       VGA_VS,
  output logic [1:0] oDM_SEL,
  output logic       oGAUSS_EN,
  output logic       oAWB_EN,
  output logic       oGAMMA_EN,
  output logic       oGAMMA_SQ,
  output logic       oCFG_UPD,
  output logic       oAWB_CLR,
  output logic       oMUTE,
  output logic       oBUSY
);

  localparam logic VS_IDLE_LVL = (VS_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [5:0]       swS;
  logic [CFG_W-1:0] cfgRaw;
  logic [CFG_W-1:0] stable;
  logic [CFG_W-1:0] active;
  ctrlState_t       state;
  logic [3:0]       fcnt;
  logic             vsPrev;
  logic             vsEdge;
  logic             awbRise;
  logic             dmChange;
  logic             unusedSwLo;

  assign unusedSwLo = ^SW[3:0];

  sw_debounce #(
    .W          (CFG_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) uDeb (
    .clk       (CLK),
    .rstN      (RST_N),
    .rawIn     (SW[9:4]),
    .syncOut   (swS),
    .candIn    (cfgRaw),
    .stableOut (stable)
  );

  assign cfgRaw = encodeCfg(swS);

  // vsPrev resets to the inactive level so leaving reset never looks like an edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) vsPrev <= VS_IDLE_LVL;
    else        vsPrev <= VGA_VS;
  end

  assign vsEdge = (VS_ACTIVE_LOW != 0) ? (vsPrev & ~VGA_VS) : (~vsPrev & VGA_VS);

  assign awbRise  = ~active[CFG_AWB] & stable[CFG_AWB];
  assign dmChange = active[CFG_DM_HI:CFG_DM_LO] != stable[CFG_DM_HI:CFG_DM_LO];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      active   <= '0;
      fcnt     <= '0;
      oCFG_UPD <= 1'b0;
      oAWB_CLR <= 1'b0;
      oMUTE    <= 1'b0;
      oBUSY    <= 1'b0;
    end else begin
      oCFG_UPD <= 1'b0;
      oAWB_CLR <= 1'b0;
      case (state)
        S_IDLE: begin
          if (stable != active) begin
            state <= S_PEND;
            oBUSY <= 1'b1;
          end
        end
        S_PEND: begin
          if (stable == active) begin
            state <= S_IDLE;
            oBUSY <= 1'b0;
          end else if (vsEdge) begin
            active   <= stable;
            oCFG_UPD <= 1'b1;
            oAWB_CLR <= awbRise | dmChange;
            if (FLUSH_FRAMES > 0) begin
              fcnt  <= 4'(FLUSH_FRAMES);
              oMUTE <= 1'b1;
              state <= S_FLUSH;
            end else begin
              state <= S_IDLE;
              oBUSY <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          // Any stable change here waits: IDLE must be re-entered first, so
          // the edge that ends the flush can never also commit.
          if (vsEdge) begin
            fcnt <= fcnt - 4'd1;
            if (fcnt == 4'd1) begin
              oMUTE <= 1'b0;
              state <= S_IDLE;
              oBUSY <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          oMUTE <= 1'b0;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

  assign oDM_SEL   = active[CFG_DM_HI:CFG_DM_LO];
  assign oGAUSS_EN = active[CFG_GAUSS];
  assign oAWB_EN   = active[CFG_AWB];
  assign oGAMMA_EN = active[CFG_GEN];
  assign oGAMMA_SQ = active[CFG_GSQ];

endmodule

// File: tb/tb_isp_mode_ctrl.sv
`timescale 1ns/1ps
module tb_isp_mode_ctrl;

  localparam int DEB   = 4;
  localparam int FLUSH = 2;
  localparam int FRAME = 100;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [9:0] SW = 10'h3F0;
  logic       VGA_VS = 1'b1;
  logic [1:0] oDM_SEL;
  logic       oGAUSS_EN, oAWB_EN, oGAMMA_EN, oGAMMA_SQ;
  logic       oCFG_UPD, oAWB_CLR, oMUTE, oBUSY;

  int total = 0;
  int bad   = 0;
  int modelBad = 0;
  int phase = 0;

  isp_mode_ctrl #(
    .DEB_CYCLES    (DEB),
    .FLUSH_FRAMES  (FLUSH),
    .VS_ACTIVE_LOW (1)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SW        (SW),
    .VGA_VS    (VGA_VS),
    .oDM_SEL   (oDM_SEL),
    .oGAUSS_EN (oGAUSS_EN),
    .oAWB_EN   (oAWB_EN),
    .oGAMMA_EN (oGAMMA_EN),
    .oGAMMA_SQ (oGAMMA_SQ),
    .oCFG_UPD  (oCFG_UPD),
    .oAWB_CLR  (oAWB_CLR),
    .oMUTE     (oMUTE),
    .oBUSY     (oBUSY)
  );

  always #5 CLK = ~CLK;

  // vsync: low for 4 cycles out of every FRAME, one falling edge per frame
  initial begin
    forever begin
      @(negedge CLK);
      phase  = (phase + 1) % FRAME;
      VGA_VS = (phase >= 4);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Stable = the encoded switch value once the encoded samples taken
  // 2..2+DEB edges ago are all equal (2-flop sync + DEB+1 equal samples).
  logic [5:0] mHist[$];
  logic [5:0] mStable = '0;
  logic [5:0] mActive = '0;
  bit         mWait = 0;
  int         mFlush = 0;
  bit         mUpd = 0, mClr = 0, mMute = 0;
  logic       mVsPrev = 1'b1;

  function automatic logic [5:0] enc(input logic [9:0] s);
    int dm;
    dm = s[8] ? 2 : (s[9] ? 1 : 0);
    return {2'(dm), s[7:4]};
  endfunction

  task automatic modelStep();
    bit vsEdge;
    bit same;
    if (!RST_N) begin
      mHist.delete();
      for (int i = 0; i < DEB + 3; i++) mHist.push_back(6'd0);
      mStable = '0; mActive = '0; mWait = 0; mFlush = 0;
      mUpd = 0; mClr = 0; mMute = 0; mVsPrev = 1'b1;
    end else begin
      vsEdge  = mVsPrev && !VGA_VS;
      mVsPrev = VGA_VS;
      mUpd = 0; mClr = 0;
      if (mFlush > 0) begin
        if (vsEdge) begin
          mFlush = mFlush - 1;
          if (mFlush == 0) mMute = 0;
        end
      end else if (mWait) begin
        if (mStable == mActive) mWait = 0;
        else if (vsEdge) begin
          mUpd = 1;
          mClr = (!mActive[2] && mStable[2]) || (mActive[5:4] != mStable[5:4]);
          mActive = mStable;
          mWait = 0;
          mFlush = FLUSH;
          mMute = (FLUSH > 0);
        end
      end else if (mStable != mActive) begin
        mWait = 1;
      end
      mHist.push_back(enc(SW));
      void'(mHist.pop_front());
      same = 1;
      for (int i = 0; i <= DEB; i++) if (mHist[i] != mHist[DEB]) same = 0;
      if (same) mStable = mHist[DEB];
    end
  endtask

  initial begin
    logic [9:0] act, exp;
    forever begin
      @(posedge CLK);
      modelStep();
      #1;
      act = {oDM_SEL, oGAUSS_EN, oAWB_EN, oGAMMA_EN, oGAMMA_SQ, oCFG_UPD, oAWB_CLR, oMUTE, oBUSY};
      exp = {mActive, mUpd, mClr, mMute, (mWait || mFlush > 0)};
      total++;
      if (act !== exp) begin
        bad++;
        modelBad++;
        if (modelBad <= 20)
          $display("FAIL model t=%0t: got %b expected %b", $time, act, exp);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic waitUpd(input int budget, output int n, output bit got);
    n = 0; got = 0;
    while (n < budget) begin
      @(negedge CLK);
      n++;
      if (oCFG_UPD === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  // Called at the negedge showing the oCFG_UPD pulse; returns cycles until oMUTE drops.
  task automatic muteLen(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n == 1) chk("upd_single_pulse", int'(oCFG_UPD) + int'(oAWB_CLR), 0);
    end while (oMUTE === 1'b1 && n < 400);
  endtask

  typedef struct {
    logic [9:0] sw;
    int dm;
    bit gauss, awb, gen, gsq, clr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int  n, m;
    bit  got, seen;
    vecs[0] = '{10'h3F0, 2, 1, 1, 1, 1, 1};
    vecs[1] = '{10'h100, 2, 0, 0, 0, 0, 0};
    vecs[2] = '{10'h330, 2, 0, 0, 1, 1, 0};
    vecs[3] = '{10'h220, 1, 0, 0, 1, 0, 1};
    vecs[4] = '{10'h040, 0, 0, 1, 0, 0, 1};
    vecs[5] = '{10'h0C0, 0, 1, 1, 0, 0, 0};
    vecs[6] = '{10'h080, 0, 1, 0, 0, 0, 0};
    vecs[7] = '{10'h04F, 0, 0, 1, 0, 0, 1};
    vecs[8] = '{10'h000, 0, 0, 0, 0, 0, 0};

    // reset with switches set
    RST_N = 1'b0; SW = 10'h3F0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", {oDM_SEL, oGAUSS_EN, oAWB_EN, oGAMMA_EN, oGAMMA_SQ, oCFG_UPD, oAWB_CLR, oMUTE, oBUSY}, 0);
    RST_N = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (oCFG_UPD === 1'b1) seen = 1;
    end
    chk("no_early_upd", seen, 0);

    // table of commits
    foreach (vecs[i]) begin
      SW = vecs[i].sw;
      waitUpd(400, n, got);
      chk("commit_seen", got, 1);
      chk("dm", oDM_SEL, vecs[i].dm);
      chk("gauss", oGAUSS_EN, vecs[i].gauss);
      chk("awb", oAWB_EN, vecs[i].awb);
      chk("gamma_en", oGAMMA_EN, vecs[i].gen);
      chk("gamma_sq", oGAMMA_SQ, vecs[i].gsq);
      chk("awb_clr", oAWB_CLR, vecs[i].clr);
      chk("mute_on", oMUTE, 1);
      muteLen(m);
      chk("mute_len", m, 2 * FRAME);
      chk("busy_after_flush", oBUSY, 0);
    end

    // bounce on SW[7], shorter than the debounce window
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (oCFG_UPD === 1'b1 || oBUSY === 1'b1) seen = 1;
      if (c % 3 == 2) SW[7] = ~SW[7];
    end
    repeat (300) begin
      @(negedge CLK);
      if (oCFG_UPD === 1'b1 || oBUSY === 1'b1) seen = 1;
    end
    chk("bounce_no_activity", seen, 0);
    chk("bounce_gauss", oGAUSS_EN, 0);

    // revert while pending
    while (phase != 5) @(posedge CLK);
    @(negedge CLK);
    SW = 10'h040;
    repeat (15) @(negedge CLK);
    chk("revert_pending_busy", oBUSY, 1);
    SW = 10'h000;
    repeat (15) @(negedge CLK);
    chk("revert_back_idle", oBUSY, 0);
    seen = 0;
    repeat (250) begin
      @(negedge CLK);
      if (oCFG_UPD === 1'b1 || oAWB_CLR === 1'b1) seen = 1;
    end
    chk("revert_no_commit", seen, 0);

    // change during flush
    SW = 10'h080;
    waitUpd(400, n, got);
    chk("flush_first_commit", got, 1);
    n = 0;
    repeat (110) begin
      @(negedge CLK);
      n++;
    end
    SW = 10'h0A0;
    got = 0;
    while (n < 600 && !got) begin
      @(negedge CLK);
      n++;
      if (oCFG_UPD === 1'b1) got = 1;
    end
    chk("flush_change_delay", n, 3 * FRAME);
    chk("flush_change_gamma", oGAMMA_EN, 1);
    chk("flush_change_clr", oAWB_CLR, 0);
    chk("flush_change_mute", oMUTE, 1);
    muteLen(m);
    chk("flush_change_mute_len", m, 2 * FRAME);

    // reset mid-flush and mid-pending
    SW = 10'h0C0;
    waitUpd(400, n, got);
    chk("rst_commit_seen", got, 1);
    repeat (50) @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_flush_abort", {oDM_SEL, oGAUSS_EN, oAWB_EN, oGAMMA_EN, oGAMMA_SQ, oCFG_UPD, oAWB_CLR, oMUTE, oBUSY}, 0);
    RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    chk("rst_pending_busy", oBUSY, 1);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_pending_abort", {oCFG_UPD, oMUTE, oBUSY}, 0);
    RST_N = 1'b1;
    waitUpd(400, n, got);
    chk("rst_recommit", got, 1);
    chk("rst_recommit_clr", oAWB_CLR, 1);
    muteLen(m);

    // randomized stimulus, checked every cycle by the model
    for (int it = 0; it < 70; it++) begin
      int hold;
      @(negedge CLK);
      SW = 10'($urandom);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(5, 250);
      if ($urandom_range(0, 19) == 0) begin
        RST_N = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge CLK);
        RST_N = 1'b1;
      end
      repeat (hold) @(negedge CLK);
    end
    repeat (400) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
